// File: rtl/hazard_sched.sv
// Stall/flush scheduler for the 5-stage pipeline with MDU busy sequencing.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter.
module hazard_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [1:0]  tuseRsD,
  input  logic [1:0]  tuseRtD,
  input  logic        isMdD,
  input  logic [4:0]  waE,
  input  logic [1:0]  tnewE,
  input  logic [4:0]  waM,
  input  logic [1:0]  tnewM,
  input  logic        startMultE,
  input  logic        startDivE,
  output logic        stall,
  output logic        enPC,
  output logic        enFD,
  output logic        flushDE,
  output logic        mdBusy,
  output logic        mdDone
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stallCnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n;
  logic             stallRs, stallRt, stallMd;

  // Equal tnew/tuse is covered by forwarding, so only strict > stalls.
  always_comb begin
    stallRs = (rsD != 5'd0) &&
              ((rsD == waE && tnewE > tuseRsD) ||
               (rsD == waM && tnewM > tuseRsD));
    stallRt = (rtD != 5'd0) &&
              ((rtD == waE && tnewE > tuseRtD) ||
               (rtD == waM && tnewM > tuseRtD));
    stallMd = isMdD && (mdBusy || startMultE || startDivE);
    stall   = stallRs | stallRt | stallMd;
    enPC    = ~stall;
    enFD    = ~stall;
    flushDE = stall;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (startDivE) begin
          state_n = BUSY;
          cnt_n   = CNT_W'(DIV_LAT);
        end else if (startMultE) begin
          state_n = BUSY;
          cnt_n   = CNT_W'(MULT_LAT);
        end
      end
      BUSY: begin
        // Starts here are illegal and deliberately ignored.
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n == BUSY);
    done_n = busy_n && (cnt_n == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mdBusy <= 1'b0;
      mdDone <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mdBusy <= busy_n;
      mdDone <= done_n;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stallCnt <= '0;
    else if (stall && stallCnt != 32'hFFFF_FFFF)
      stallCnt <= stallCnt + 32'd1;
  end
`endif

endmodule
